ex_muldiv_unit: RTL and testbench

- Parametrised multi-cycle RV32M/RV64M multiply/divide unit that sits in the EX stage beside the single-cycle ALU.
- Performs the same 2-bit forwarding-source selection as the EX operand muxes, then captures the operands.
- Runs an iterative radix-2 shift-add (multiply) or restoring (divide) datapath.
- Holds the pipeline with a stall output until the result is ready.

---
 rtl/ex_muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M/RV64M multiply/divide unit: forwarding operand select, iterative
// radix-2 shift-add multiply / restoring divide, pipeline stall until the result is ready.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            is_m_op,
  input  logic            flush,
  input  logic [2:0]      m_funct3,
  input  logic [XLEN-1:0] reg_out1,
  input  logic [XLEN-1:0] reg_out2,
  input  logic [XLEN-1:0] EX_MEM_result,
  input  logic [XLEN-1:0] MEM_WB_result,
  input  logic [1:0]      op1_fwd_src,
  input  logic [1:0]      op2_fwd_src,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_hi, r_lo, r_opb;
  logic [2:0]        r_f3;
  logic              r_neg;
  logic [XLEN-1:0]   r_result;
  logic              r_result_valid;

  logic [XLEN-1:0]   w_op1, w_op2, w_a_mag, w_b_mag, w_special_res;
  logic              w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg;
  logic              w_div_zero, w_div_ovf, w_special, w_start, w_last;
  logic [XLEN:0]     w_add, w_shift;
  logic              w_qbit;
  logic [XLEN-1:0]   w_hi_nxt, w_lo_nxt, w_quot, w_rem, w_final;
  logic [2*XLEN-1:0] w_prod, w_prod_s;

  function automatic logic [XLEN-1:0] fwd_sel(input logic [1:0]      src,
                                               input logic [XLEN-1:0] rf,
                                               input logic [XLEN-1:0] exm,
                                               input logic [XLEN-1:0] mwb);
    unique case (src)
      2'b10:   return exm;
      2'b11:   return mwb;
      default: return rf;
    endcase
  endfunction

  assign w_op1   = fwd_sel(op1_fwd_src, reg_out1, EX_MEM_result, MEM_WB_result);
  assign w_op2   = fwd_sel(op2_fwd_src, reg_out2, EX_MEM_result, MEM_WB_result);
  assign w_start = in_valid & is_m_op & ~flush & (r_state == S_IDLE);
  assign w_last  = (r_cnt == CW'(XLEN-1));

  // Decode signedness and special cases from the live operands in the accept cycle.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_is_div      = m_funct3[2];
    w_a_signed    = 1'b0;
    w_b_signed    = 1'b0;
    w_special_res = '0;
    if (w_is_div) begin
      w_a_signed = ~m_funct3[0];
      w_b_signed = ~m_funct3[0];
    end else begin
      w_a_signed = (m_funct3[1:0] == 2'b01) || (m_funct3[1:0] == 2'b10);
      w_b_signed = (m_funct3[1:0] == 2'b01);
    end
    w_a_neg    = w_a_signed & w_op1[XLEN-1];
    w_b_neg    = w_b_signed & w_op2[XLEN-1];
    w_a_mag    = w_a_neg ? -w_op1 : w_op1;
    w_b_mag    = w_b_neg ? -w_op2 : w_op2;
    // Remainder follows the dividend; quotient and product follow the sign difference.
    w_neg      = (w_is_div && m_funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_div_zero = w_is_div & (w_op2 == '0);
    w_div_ovf  = w_is_div & ~m_funct3[0] & (w_op1 == MOST_NEG) & (w_op2 == '1);
    w_special  = w_div_zero | w_div_ovf;
    if (w_div_zero)
      w_special_res = m_funct3[1] ? w_op1 : '1;
    else if (w_div_ovf)
      w_special_res = m_funct3[1] ? '0 : w_op1;
  end

  // One radix-2 step: r_hi is the partial product / running remainder,
  // r_lo holds the multiplier bits or collects quotient bits.
  assign w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_qbit  = (w_shift >= {1'b0, r_opb});

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_state == S_MUL) begin
      {w_hi_nxt, w_lo_nxt} = {w_add, r_lo[XLEN-1:1]};
    end else if (r_state == S_DIV) begin
      w_hi_nxt = w_qbit ? XLEN'(w_shift - {1'b0, r_opb}) : XLEN'(w_shift);
      w_lo_nxt = {r_lo[XLEN-2:0], w_qbit};
    end
  end

  assign w_prod   = {w_hi_nxt, w_lo_nxt};
  assign w_prod_s = r_neg ? -w_prod : w_prod;
  assign w_quot   = r_neg ? -w_lo_nxt : w_lo_nxt;
  assign w_rem    = r_neg ? -w_hi_nxt : w_hi_nxt;

  always_comb begin
    w_final = '0;
    if (r_f3[2])
      w_final = r_f3[1] ? w_rem : w_quot;
    else
      w_final = (r_f3[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:       if (w_start) w_state_nxt = w_special ? S_DONE : (m_funct3[2] ? S_DIV : S_MUL);
      S_MUL, S_DIV: if (w_last)  w_state_nxt = S_DONE;
      S_DONE:       w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: datapath registers are reset too, so no stale partial result survives an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_hi           <= '0;
      r_lo           <= '0;
      r_opb          <= '0;
      r_f3           <= '0;
      r_neg          <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= (w_state_nxt == S_DONE);
      if (w_state_nxt == S_DONE)
        r_result <= (r_state == S_IDLE) ? w_special_res : w_final;
      if (w_start) begin
        r_f3  <= m_funct3;
        r_neg <= w_neg;
        r_cnt <= '0;
        r_hi  <= '0;
        r_lo  <= w_is_div ? w_a_mag : w_b_mag;
        r_opb <= w_is_div ? w_b_mag : w_a_mag;
      end else if (r_state == S_MUL || r_state == S_DIV) begin
        r_hi  <= w_hi_nxt;
        r_lo  <= w_lo_nxt;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Release the pipeline in DONE so the op advances and is not re-accepted.
  assign stall        = rst_n & in_valid & is_m_op & ~flush & (r_state != S_DONE);
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: arithmetic reference model feeding a
// scoreboard queue, with an independent monitor checking result value and cycle.
module tb_ex_muldiv_unit;
  localparam int XLEN = 32;
  localparam logic [31:0] MOST_NEG = 32'h8000_0000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, is_m_op = 1'b0, flush = 1'b0;
  logic [2:0]  m_funct3 = '0;
  logic [31:0] reg_out1 = '0, reg_out2 = '0, EX_MEM_result = '0, MEM_WB_result = '0;
  logic [1:0]  op1_fwd_src = '0, op2_fwd_src = '0;
  logic        stall, result_valid, busy;
  logic [31:0] result;

  ex_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .is_m_op(is_m_op), .flush(flush),
    .m_funct3(m_funct3), .reg_out1(reg_out1), .reg_out2(reg_out2),
    .EX_MEM_result(EX_MEM_result), .MEM_WB_result(MEM_WB_result),
    .op1_fwd_src(op1_fwd_src), .op2_fwd_src(op2_fwd_src),
    .stall(stall), .result(result), .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0, op_id = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the instruction semantics.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sa, sbv;
    sa = a; sbv = b;
    case (f3)
      3'd0: begin up = 64'(a) * 64'(b); return up[31:0]; end
      3'd1: begin sp = longint'(sa) * longint'(sbv); return sp[63:32]; end
      3'd2: begin sp = longint'(sa) * longint'({32'h0, b}); return sp[63:32]; end
      3'd3: begin up = 64'(a) * 64'(b); return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MOST_NEG && b == 32'hFFFF_FFFF) return a;
        return sa / sbv;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MOST_NEG && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sbv;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == MOST_NEG && b == 32'hFFFF_FFFF));
  endfunction

  typedef struct { logic [31:0] res; int cyc; int id; } exp_t;
  exp_t scoreboard[$];
  exp_t mon_e;

  // Monitor: every result_valid pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (scoreboard.size() == 0) begin
        check("spurious_result_valid", 1, 0);
      end else begin
        mon_e = scoreboard.pop_front();
        check($sformatf("op%0d_result", mon_e.id), result, mon_e.res);
        check($sformatf("op%0d_valid_cycle", mon_e.id), cyc, mon_e.cyc);
      end
    end
  end

  task automatic scramble();
    reg_out1 = $urandom; reg_out2 = $urandom;
    EX_MEM_result = $urandom; MEM_WB_result = $urandom;
  endtask

  task automatic drive_ops(input logic [2:0] f3, input logic [31:0] v1, input logic [31:0] v2,
                           input logic [1:0] s1, input logic [1:0] s2);
    scramble();
    m_funct3 = f3; op1_fwd_src = s1; op2_fwd_src = s2;
    case (s1)
      2'b10:   EX_MEM_result = v1;
      2'b11:   MEM_WB_result = v1;
      default: reg_out1 = v1;
    endcase
    case (s2)
      2'b10:   EX_MEM_result = v2;
      2'b11:   MEM_WB_result = v2;
      default: reg_out2 = v2;
    endcase
    in_valid = 1'b1; is_m_op = 1'b1;
  endtask

  // Issue one M-op at the next negedge; returns in its DONE cycle with in_valid still high.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] v1, input logic [31:0] v2_in,
                        input logic [1:0] s1, input logic [1:0] s2, input bit drop);
    logic [31:0] v2;
    int lat, n, k, id;
    bit done;
    v2 = (s1[1] && s2 == s1) ? v1 : v2_in;
    lat = is_special(f3, v1, v2) ? 1 : XLEN + 1;
    id = op_id++;
    @(negedge clk);
    drive_ops(f3, v1, v2, s1, s2);
    scoreboard.push_back('{res: ref_model(f3, v1, v2), cyc: cyc + lat, id: id});
    #1 check($sformatf("op%0d_stall_accept", id), stall, 1);
    if (drop) begin
      k = 0;
      while (scoreboard.size() > 0 && k < XLEN + 8) begin
        @(negedge clk); scramble(); in_valid = 1'b0; #1; k++;
      end
      check($sformatf("op%0d_drained", id), scoreboard.size(), 0);
    end else begin
      n = 1; done = 1'b0;
      while (!done && n <= XLEN + 4) begin
        @(negedge clk); scramble(); #1;
        if (!stall) done = 1'b1; else n++;
      end
      check($sformatf("op%0d_stall_cycles", id), n, lat);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1)); is_m_op = 1'b0; scramble();
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return MOST_NEG;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b1; is_m_op = 1'b1;
    #12;
    check("reset_result", result, 0);
    check("reset_result_valid", result_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_stall", stall, 0);
    in_valid = 1'b0; is_m_op = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 2'b00, 2'b00, 1'b0);
    run_op(3'd1, MOST_NEG, MOST_NEG, 2'b01, 2'b00, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 2'b01, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 2'b00, 1'b0);
    run_op(3'd4, -32'sd7, 32'd2, 2'b00, 2'b00, 1'b0);
    run_op(3'd6, -32'sd7, 32'd2, 2'b00, 2'b00, 1'b0);
    run_op(3'd5, 32'd100, 32'd7, 2'b00, 2'b00, 1'b0);
    run_op(3'd7, 32'd100, 32'd7, 2'b00, 2'b00, 1'b0);
    run_op(3'd5, 32'd1234, 32'd0, 2'b00, 2'b00, 1'b0);
    run_op(3'd6, 32'd5, 32'd0, 2'b00, 2'b00, 1'b0);
    run_op(3'd4, MOST_NEG, 32'hFFFF_FFFF, 2'b00, 2'b00, 1'b0);
    run_op(3'd6, MOST_NEG, 32'hFFFF_FFFF, 2'b00, 2'b00, 1'b0);
    run_op(3'd0, 32'd9, 32'd3, 2'b10, 2'b11, 1'b0);
    run_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 2'b00, 2'b00, 1'b1);
    idle(2);

    // Flush ten cycles into a DIV: no result, FSM back to idle next edge.
    @(negedge clk);
    drive_ops(3'd4, 32'd1000, 32'd7, 2'b00, 2'b00);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1 check("flush_stall", stall, 0);
    check("flush_busy_before", busy, 1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; is_m_op = 1'b0;
    #1 check("flush_busy_after", busy, 0);
    seen = 0;
    repeat (40) begin @(negedge clk); #1 seen += int'(result_valid); end
    check("flush_no_result", seen, 0);

    // Reset five cycles into a MUL, then a fresh MUL must still be exact.
    @(negedge clk);
    drive_ops(3'd0, 32'd123, 32'd456, 2'b00, 2'b00);
    repeat (5) @(negedge clk);
    #1 check("rst_mid_busy_before", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_result", result, 0);
    check("rst_mid_result_valid", result_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_stall", stall, 0);
    @(negedge clk); in_valid = 1'b0; is_m_op = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_op(3'd0, 32'd123, 32'd456, 2'b00, 2'b00, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), rnd_val(), rnd_val(),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(3);
    check("final_scoreboard_empty", scoreboard.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
